// File: rtl/audio_codec_pkg.sv
// Shared definitions for the audio codec path: default sample width,
// DAC serializer state encoding and the stereo sample pair layout.
package audio_codec_pkg;

    localparam int AUDIO_DATA_WIDTH = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } dac_state_t;

    typedef struct packed {
        logic [AUDIO_DATA_WIDTH-1:0] left;
        logic [AUDIO_DATA_WIDTH-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Small single-clock FIFO of stereo pairs. The head entry is presented
// combinationally so the consumer can load it in the same cycle it pops.
// Push while full and pop while empty are ignored.
module sample_fifo
    import audio_codec_pkg::*;
#(
    parameter int  FIFO_DEPTH = 4,
    parameter type elem_t     = stereo_sample_t,
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  elem_t            push_data,
    input  logic             pop,
    output elem_t            head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    elem_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_reg];
    assign count   = count_reg;

    // Storage write; entries need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S transmit serializer for the WM8731 DAC. Stereo pairs are buffered in
// a small FIFO and shifted out MSB-first on AUD_DACDAT, one BCLK after each
// DACLRCK edge, with BCLK/DACLRCK sampled into the clk domain.
// Build option: define DAC_UNDERFLOW_REPEAT_EN to repeat the last popped
// pair on underflow instead of sending silence.
module audio_dac_serializer
    import audio_codec_pkg::*;
#(
    parameter int DATA_WIDTH = AUDIO_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] writedata_left,
    input  logic [DATA_WIDTH-1:0] writedata_right,
    output logic                  write_ready,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT,
    output logic                  underflow
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BCNT_W = $clog2(DATA_WIDTH + 1);

    // Same layout as stereo_sample_t, sized by this instance's DATA_WIDTH.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] left;
        logic [DATA_WIDTH-1:0] right;
    } pair_t;

    // [0],[1] are the synchronizer stages, [2] is the history flop.
    logic [2:0] bclk_sync_reg;
    logic [2:0] lrck_sync_reg;
    logic       bclk_fall;
    logic       lrck_fall;
    logic       lrck_rise;

    dac_state_t state_reg;
    dac_state_t state_next;

    logic [DATA_WIDTH-1:0] shreg_l_reg;
    logic [DATA_WIDTH-1:0] shreg_r_reg;
    logic [BCNT_W-1:0]     bitcnt_reg;
    logic                  dacdat_reg;
    logic                  underflow_reg;

    pair_t             push_pair;
    pair_t             fifo_head;
    pair_t             load_pair;
    logic              fifo_push;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

`ifdef DAC_UNDERFLOW_REPEAT_EN
    pair_t             last_pair_reg;
`endif

    assign write_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign fifo_push   = write && write_ready;
    assign push_pair   = {writedata_left, writedata_right};

    assign bclk_fall = bclk_sync_reg[2] & ~bclk_sync_reg[1];
    assign lrck_fall = lrck_sync_reg[2] & ~lrck_sync_reg[1];
    assign lrck_rise = ~lrck_sync_reg[2] & lrck_sync_reg[1];

    assign AUD_DACDAT = dacdat_reg;
    assign underflow  = underflow_reg;

    sample_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .elem_t     (pair_t)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (push_pair),
        .pop       (lrck_fall),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Bring the codec clocks into the clk domain and keep one history sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync_reg <= '0;
            lrck_sync_reg <= '0;
        end else begin
            bclk_sync_reg <= {bclk_sync_reg[1:0], AUD_BCLK};
            lrck_sync_reg <= {lrck_sync_reg[1:0], AUD_DACLRCK};
        end
    end

    // Pair loaded at a left-frame start; an empty FIFO supplies the fill pair.
    always_comb begin
        load_pair = fifo_head;
        if (fifo_empty) begin
`ifdef DAC_UNDERFLOW_REPEAT_EN
            load_pair = last_pair_reg;
`else
            load_pair = '0;
`endif
        end
    end

`ifdef DAC_UNDERFLOW_REPEAT_EN
    // Remember the last real pair so an underflow can repeat it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_pair_reg <= '0;
        end else if (lrck_fall && !fifo_empty) begin
            last_pair_reg <= fifo_head;
        end
    end
`endif

    // Frame state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: every LRCK fall starts a left channel, so alignment is
    // always left-first, and a rise only matters once in the left channel.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (lrck_fall) begin
                    state_next = LEFT;
                end
            end
            LEFT: begin
                if (lrck_fall) begin
                    state_next = LEFT;
                end else if (lrck_rise) begin
                    state_next = RIGHT;
                end
            end
            RIGHT: begin
                if (lrck_fall) begin
                    state_next = LEFT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Channel loading, bit emission and underflow flag. An LRCK edge takes
    // priority over a coincident BCLK fall, which yields the one-BCLK delay.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_l_reg   <= '0;
            shreg_r_reg   <= '0;
            bitcnt_reg    <= '0;
            dacdat_reg    <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            underflow_reg <= 1'b0;
            if (lrck_fall) begin
                shreg_l_reg   <= load_pair.left;
                shreg_r_reg   <= load_pair.right;
                bitcnt_reg    <= '0;
                underflow_reg <= fifo_empty;
            end else if (lrck_rise) begin
                if (state_reg == LEFT) begin
                    bitcnt_reg <= '0;
                end
            end else if (bclk_fall && (state_reg != IDLE)) begin
                if (bitcnt_reg < BCNT_W'(DATA_WIDTH)) begin
                    bitcnt_reg <= bitcnt_reg + BCNT_W'(1);
                    if (state_reg == LEFT) begin
                        dacdat_reg  <= shreg_l_reg[DATA_WIDTH-1];
                        shreg_l_reg <= {shreg_l_reg[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        dacdat_reg  <= shreg_r_reg[DATA_WIDTH-1];
                        shreg_r_reg <= {shreg_r_reg[DATA_WIDTH-2:0], 1'b0};
                    end
                end else begin
                    dacdat_reg <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Self-checking bench for audio_dac_serializer. A codec-side generator makes
// 64 BCLK per frame; accepted writes are queued as expected pairs and each
// frame's serial words are rebuilt and compared against the queue head.
module tb_audio_dac_serializer;

    localparam int DW    = 24;
    localparam int DEPTH = 4;
    localparam int BHALF = 100;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          write;
    logic [DW-1:0] wl;
    logic [DW-1:0] wr;
    logic          write_ready;
    logic          AUD_BCLK;
    logic          AUD_DACLRCK;
    logic          AUD_DACDAT;
    logic          underflow;

    int vec_cnt        = 0;
    int miscompare_cnt = 0;

    logic [2*DW-1:0] sb [$];
    int              bit_idx;
    logic            mon_en;
    logic            armed;
    logic [2*DW-1:0] cur_exp;
    logic [2*DW-1:0] last_exp;
    logic [DW-1:0]   lw;
    logic [DW-1:0]   rw;
    logic            pad_or;
    logic            idle_or;
    int              uf_cnt = 0;
    int              uf_prev = 0;
    int              mon_k;

    audio_dac_serializer #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .write           (write),
        .writedata_left  (wl),
        .writedata_right (wr),
        .write_ready     (write_ready),
        .AUD_BCLK        (AUD_BCLK),
        .AUD_DACLRCK     (AUD_DACLRCK),
        .AUD_DACDAT      (AUD_DACDAT),
        .underflow       (underflow)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [2*DW-1:0] got, input logic [2*DW-1:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Codec model: LRCK changes on the BCLK fall that starts slots 0 and 32.
    initial begin
        AUD_BCLK    = 1'b1;
        AUD_DACLRCK = 1'b0;
        bit_idx     = 63;
        #7;
        forever begin
            bit_idx  = (bit_idx == 63) ? 0 : bit_idx + 1;
            AUD_BCLK = 1'b0;
            if (bit_idx == 0) AUD_DACLRCK = 1'b0;
            else if (bit_idx == 32) AUD_DACLRCK = 1'b1;
            #BHALF;
            AUD_BCLK = 1'b1;
            #BHALF;
        end
    end

    always @(negedge clk) begin
        if (underflow === 1'b1) uf_cnt++;
    end

    // Frame monitor: sample AUD_DACDAT mid-bit on BCLK rise.
    always @(posedge AUD_BCLK) begin
        mon_k = bit_idx;
        if (mon_k == 0) begin
            if (armed) mon_en = 1'b1;
            check("uf_pulses", 48'(uf_cnt - uf_prev), 48'(mon_en && (sb.size() == 0)));
            uf_prev = uf_cnt;
            if (mon_en) begin
                if (sb.size() > 0) begin
                    cur_exp  = sb.pop_front();
                    last_exp = cur_exp;
                end else begin
`ifdef DAC_UNDERFLOW_REPEAT_EN
                    cur_exp = last_exp;
`else
                    cur_exp = '0;
`endif
                end
            end
            pad_or  = 1'b0;
            idle_or = 1'b0;
        end
        if (mon_k >= 1 && mon_k <= 24) lw = {lw[DW-2:0], AUD_DACDAT};
        else if (mon_k >= 33 && mon_k <= 56) rw = {rw[DW-2:0], AUD_DACDAT};
        else pad_or = pad_or | AUD_DACDAT;
        idle_or = idle_or | AUD_DACDAT;
        if (mon_en && mon_k == 24) check("left_word", 48'(lw), 48'(cur_exp[2*DW-1:DW]));
        if (mon_en && mon_k == 56) check("right_word", 48'(rw), 48'(cur_exp[DW-1:0]));
        if (mon_k == 63) begin
            if (mon_en) check("pad_zero", 48'(pad_or), 48'(0));
            else check("idle_dacdat", 48'(idle_or), 48'(0));
        end
        if (mon_k == 32 && reset_n) armed = 1'b1;
    end

    task automatic wait_frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge AUD_BCLK);
            while (bit_idx != 0) @(posedge AUD_BCLK);
        end
    endtask

    task automatic wait_slot(input int slot);
        int guard = 0;
        @(negedge clk);
        while (bit_idx != slot && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic wait_window();
        int guard = 0;
        @(negedge clk);
        while (!(bit_idx >= 4 && bit_idx <= 50) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // One write cycle, started and finished at a clk falling edge.
    task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        logic exp_rdy;
        exp_rdy = (sb.size() < DEPTH);
        check("write_ready", 48'(write_ready), 48'(exp_rdy));
        write = 1'b1;
        wl    = l;
        wr    = r;
        @(posedge clk);
        if (exp_rdy) sb.push_back({l, r});
        @(negedge clk);
    endtask

    task automatic end_write();
        write = 1'b0;
    endtask

    task automatic mid_reset();
        reset_n = 1'b0;
        write   = 1'b0;
        mon_en  = 1'b0;
        armed   = 1'b0;
        idle_or = 1'b0;
        sb.delete();
        last_exp = '0;
        #1;
        check("rst_dacdat", 48'(AUD_DACDAT), 48'(0));
        check("rst_ready", 48'(write_ready), 48'(1));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        uf_prev = uf_cnt;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset_n  = 1'b0;
        write    = 1'b0;
        wl       = '0;
        wr       = '0;
        mon_en   = 1'b0;
        armed    = 1'b0;
        cur_exp  = '0;
        last_exp = '0;
        lw       = '0;
        rw       = '0;
        pad_or   = 1'b0;
        idle_or  = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_dacdat", 48'(AUD_DACDAT), 48'(0));
        check("reset_uf", 48'(underflow), 48'(0));
        check("reset_ready", 48'(write_ready), 48'(1));
        reset_n = 1'b1;
        uf_prev = uf_cnt;

        // Idle frames with no writes: silence and one underflow per frame.
        wait_frames(2);

        // Single pair.
        wait_window();
        push_pair(24'hA5A5A5, 24'h3C3C3C);
        end_write();
        wait_frames(1);

        // Five back-to-back writes into a depth-4 FIFO.
        wait_window();
        push_pair(24'h111111, 24'h800001);
        push_pair(24'h222222, 24'h7FFFFE);
        push_pair(24'h333333, 24'hC00003);
        push_pair(24'h444444, 24'h3FFFFC);
        push_pair(24'h555555, 24'hAAAAAA);
        end_write();

        // Hold write on a full FIFO across the next LRCK fall.
        wait_slot(62);
        check("full_ready", 48'(write_ready), 48'(sb.size() < DEPTH));
        write = 1'b1;
        wl    = 24'h9ABCDE;
        wr    = 24'h0F0F0F;
        guard = 0;
        @(negedge clk);
        while (write_ready !== 1'b1 && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        check("held_ready", 48'(write_ready), 48'(1));
        if (write_ready === 1'b1) begin
            @(posedge clk);
            sb.push_back({24'h9ABCDE, 24'h0F0F0F});
            @(negedge clk);
            write = 1'b0;
            check("refill_ready", 48'(write_ready), 48'(0));
        end else begin
            write = 1'b0;
        end
        wait_frames(4);

        // Underflow after a known pair.
        wait_window();
        push_pair(24'h123456, 24'h654321);
        end_write();
        wait_frames(2);

        // Fill, then reset in the middle of an all-ones left word.
        wait_window();
        push_pair(24'hFFFFFF, 24'hFFFFFF);
        push_pair(24'h0A0B0C, 24'h0D0E0F);
        push_pair(24'h101010, 24'h202020);
        push_pair(24'h303030, 24'h404040);
        end_write();
        wait_frames(1);
        wait_window();
        push_pair(24'h505050, 24'h606060);
        end_write();
        wait_slot(10);
        repeat (4) @(negedge clk);
        check("pre_rst_ready", 48'(write_ready), 48'(sb.size() < DEPTH));
        check("pre_rst_dacdat", 48'(AUD_DACDAT), 48'(cur_exp[DW + 14]));
        mid_reset();
        wait_frames(2);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
